// File: rtl/ppu_pkg.sv
// Shared types and helpers for the PPU CPU-facing register file.
// Register indices, loopy address layout, status bit positions and palette aliasing.
package ppu_pkg;

    typedef enum logic [2:0] {
        REG_CTRL    = 3'd0,
        REG_MASK    = 3'd1,
        REG_STATUS  = 3'd2,
        REG_OAMADDR = 3'd3,
        REG_OAMDATA = 3'd4,
        REG_SCROLL  = 3'd5,
        REG_ADDR    = 3'd6,
        REG_DATA    = 3'd7
    } reg_idx_e;

    typedef struct packed {
        logic [2:0] fine_y;
        logic [1:0] nt;
        logic [4:0] coarse_y;
        logic [4:0] coarse_x;
    } loopy_t;

    localparam int STAT_VBLANK = 7;
    localparam int STAT_SPR0   = 6;
    localparam int STAT_OVF    = 5;

    localparam int PAL_ENTRIES = 32;

    // Sprite backdrop entries $10/$14/$18/$1C share storage with $00/$04/$08/$0C.
    function automatic logic [4:0] pal_alias(input logic [4:0] idx);
        if (idx[4] && (idx[1:0] == 2'b00)) begin
            return {1'b0, idx[3:0]};
        end
        return idx;
    endfunction

endpackage

// File: rtl/ppu_palette_ram.sv
// 32x6 palette storage with backdrop aliasing.
// One synchronous write port, asynchronous read ports for the CPU and the renderer.
module ppu_palette_ram
    import ppu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       we,
    input  logic [4:0] waddr,
    input  logic [5:0] wdata,
    input  logic [4:0] cpu_idx,
    output logic [5:0] cpu_color,
    input  logic [4:0] rnd_idx,
    output logic [5:0] rnd_color
);

    logic [5:0] mem [PAL_ENTRIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PAL_ENTRIES; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[pal_alias(waddr)] <= wdata;
        end
    end

    assign cpu_color = mem[pal_alias(cpu_idx)];
    assign rnd_color = mem[pal_alias(rnd_idx)];

endmodule

// File: rtl/ppu_cpu_regs.sv
// CPU-facing PPU register file: $2000-$2007 decode, loopy scroll state,
// PPUDATA buffering over a request/ack VRAM port, status/NMI and palette RAM.
module ppu_cpu_regs
    import ppu_pkg::*;
#(
    parameter int                 VADDR_W  = 14,
    parameter logic [VADDR_W-1:0] PAL_BASE = 14'h3F00,
    parameter int                 INC_DOWN = 32
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic [2:0]         CPU_ADDR,
    input  logic [7:0]         CPU_DATA_IN,
    input  logic               CPU_wren,
    input  logic               CPU_rden,
    output logic [7:0]         CPU_DATA_OUT,
    input  logic               VBLANK_SET,
    input  logic               VBLANK_CLR,
    input  logic               SPR0_HIT,
    input  logic               SPR_OVF,
    output logic               NMI_N,
    output logic               VRAM_REQ,
    output logic               VRAM_WE,
    output logic [VADDR_W-1:0] VRAM_ADDR,
    output logic [7:0]         VRAM_WDATA,
    input  logic [7:0]         VRAM_RDATA,
    input  logic               VRAM_ACK,
    output logic               BUSY,
    output logic [7:0]         OAM_ADDR,
    output logic [7:0]         OAM_WDATA,
    output logic               OAM_WE,
    input  logic [7:0]         OAM_RDATA,
    input  logic [4:0]         PAL_IDX,
    output logic [5:0]         PAL_COLOR,
    output logic [7:0]         CTRL_O,
    output logic [7:0]         MASK_O,
    output logic [VADDR_W:0]   V_O,
    output logic [VADDR_W:0]   T_O,
    output logic [2:0]         FINE_X_O
);

    localparam logic [VADDR_W:0]   INC_ONE    = (VADDR_W+1)'(1);
    localparam logic [VADDR_W:0]   INC_BIG    = (VADDR_W+1)'(INC_DOWN);
    localparam logic [VADDR_W:0]   PAL_SPAN   = (VADDR_W+1)'(256);
    localparam logic [VADDR_W-1:0] PAL_SHADOW = VADDR_W'('h1000);

    reg_idx_e reg_sel;

    logic [7:0]         ctrl;
    logic [7:0]         mask;
    logic [VADDR_W:0]   v;
    logic [VADDR_W:0]   t;
    logic [2:0]         fine_x;
    logic               w;
    logic [7:0]         rd_buf;
    logic [7:0]         latch;
    logic [7:0]         data_out;
    logic               vblank;
    logic               spr0;
    logic               ovf;
    logic               nmi_n;
    logic [7:0]         oam_addr;
    logic [7:0]         oam_wr_addr;
    logic [7:0]         oam_wdata;
    logic               oam_we;
    logic               vram_req;
    logic               vram_we;
    logic [VADDR_W-1:0] vram_addr;
    logic [7:0]         vram_wdata;

    logic [VADDR_W:0]   v_inc;
    logic [VADDR_W:0]   pal_off;
    logic               in_pal;
    logic               data_acc;
    logic               start_bus;
    logic               pal_we;
    logic               status_rd;
    logic               vblank_d;
    logic [7:0]         ctrl_d;
    logic [7:0]         rd_val;
    logic [5:0]         pal_cpu_color;

    assign reg_sel   = reg_idx_e'(CPU_ADDR);
    assign v_inc     = v + (ctrl[2] ? INC_BIG : INC_ONE);
    assign pal_off   = {1'b0, v[VADDR_W-1:0]} - {1'b0, PAL_BASE};
    assign in_pal    = (v[VADDR_W-1:0] >= PAL_BASE) && (pal_off < PAL_SPAN);
    assign data_acc  = (CPU_wren || CPU_rden) && (reg_sel == REG_DATA);
    assign pal_we    = CPU_wren && (reg_sel == REG_DATA) && in_pal;
    // Palette writes never touch the bus; accesses arriving while busy are dropped.
    assign start_bus = data_acc && !vram_req && !pal_we;
    assign status_rd = CPU_rden && (reg_sel == REG_STATUS);
    assign ctrl_d    = (CPU_wren && (reg_sel == REG_CTRL)) ? CPU_DATA_IN : ctrl;

    // A coincident VBLANK_SET beats a status read; VBLANK_CLR beats both.
    always_comb begin
        vblank_d = vblank;
        if (VBLANK_CLR) begin
            vblank_d = 1'b0;
        end else if (VBLANK_SET) begin
            vblank_d = 1'b1;
        end else if (status_rd) begin
            vblank_d = 1'b0;
        end
    end

    always_comb begin
        rd_val = latch;
        case (reg_sel)
            REG_STATUS: begin
                rd_val[STAT_VBLANK] = vblank & ~VBLANK_SET;
                rd_val[STAT_SPR0]   = spr0;
                rd_val[STAT_OVF]    = ovf;
            end
            REG_OAMDATA: rd_val = OAM_RDATA;
            REG_DATA:    rd_val = in_pal ? {latch[7:6], pal_cpu_color} : rd_buf;
            default:     ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ctrl   <= '0;
            mask   <= '0;
            v      <= '0;
            t      <= '0;
            fine_x <= '0;
            w      <= 1'b0;
        end else if (CPU_wren) begin
            case (reg_sel)
                REG_CTRL: begin
                    ctrl     <= CPU_DATA_IN;
                    t[11:10] <= CPU_DATA_IN[1:0];
                end
                REG_MASK: mask <= CPU_DATA_IN;
                REG_SCROLL: begin
                    if (!w) begin
                        t[4:0] <= CPU_DATA_IN[7:3];
                        fine_x <= CPU_DATA_IN[2:0];
                        w      <= 1'b1;
                    end else begin
                        t[14:12] <= CPU_DATA_IN[2:0];
                        t[9:5]   <= CPU_DATA_IN[7:3];
                        w        <= 1'b0;
                    end
                end
                REG_ADDR: begin
                    if (!w) begin
                        t[13:8] <= CPU_DATA_IN[5:0];
                        t[14]   <= 1'b0;
                        w       <= 1'b1;
                    end else begin
                        t[7:0] <= CPU_DATA_IN;
                        v      <= {t[VADDR_W:8], CPU_DATA_IN};
                        w      <= 1'b0;
                    end
                end
                REG_DATA: v <= v_inc;
                default:  ;
            endcase
        end else if (CPU_rden) begin
            if (reg_sel == REG_DATA) begin
                v <= v_inc;
            end
            if (reg_sel == REG_STATUS) begin
                w <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            data_out <= '0;
            latch    <= '0;
        end else if (CPU_rden) begin
            data_out <= rd_val;
            latch    <= rd_val;
        end else if (CPU_wren) begin
            latch <= CPU_DATA_IN;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vblank <= 1'b0;
            spr0   <= 1'b0;
            ovf    <= 1'b0;
            nmi_n  <= 1'b1;
        end else begin
            vblank <= vblank_d;
            if (VBLANK_CLR) begin
                spr0 <= 1'b0;
                ovf  <= 1'b0;
            end else begin
                if (SPR0_HIT) spr0 <= 1'b1;
                if (SPR_OVF)  ovf  <= 1'b1;
            end
            nmi_n <= ~(vblank_d & ctrl_d[7]);
        end
    end

    // A palette read still refills the buffer from the nametable underneath.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vram_req   <= 1'b0;
            vram_we    <= 1'b0;
            vram_addr  <= '0;
            vram_wdata <= '0;
            rd_buf     <= '0;
        end else if (vram_req) begin
            if (VRAM_ACK) begin
                vram_req <= 1'b0;
                vram_we  <= 1'b0;
                if (!vram_we) begin
                    rd_buf <= VRAM_RDATA;
                end
            end
        end else if (start_bus) begin
            vram_req   <= 1'b1;
            vram_we    <= CPU_wren;
            vram_addr  <= (CPU_rden && in_pal) ? (v[VADDR_W-1:0] - PAL_SHADOW)
                                               : v[VADDR_W-1:0];
            vram_wdata <= CPU_DATA_IN;
        end
    end

    // The write pulse lags the CPU strobe, so the written address is held
    // separately from the already-incremented OAMADDR.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            oam_addr    <= '0;
            oam_wr_addr <= '0;
            oam_wdata   <= '0;
            oam_we      <= 1'b0;
        end else begin
            oam_we <= 1'b0;
            if (CPU_wren && (reg_sel == REG_OAMADDR)) begin
                oam_addr <= CPU_DATA_IN;
            end else if (CPU_wren && (reg_sel == REG_OAMDATA)) begin
                oam_we      <= 1'b1;
                oam_wdata   <= CPU_DATA_IN;
                oam_wr_addr <= oam_addr;
                oam_addr    <= oam_addr + 8'd1;
            end
        end
    end

    ppu_palette_ram u_pal (
        .clk       (CLK),
        .rst_n     (RESET_N),
        .we        (pal_we),
        .waddr     (v[4:0]),
        .wdata     (CPU_DATA_IN[5:0]),
        .cpu_idx   (v[4:0]),
        .cpu_color (pal_cpu_color),
        .rnd_idx   (PAL_IDX),
        .rnd_color (PAL_COLOR)
    );

    assign CPU_DATA_OUT = data_out;
    assign NMI_N        = nmi_n;
    assign VRAM_REQ     = vram_req;
    assign VRAM_WE      = vram_we;
    assign VRAM_ADDR    = vram_addr;
    assign VRAM_WDATA   = vram_wdata;
    assign BUSY         = vram_req;
    assign OAM_ADDR     = oam_we ? oam_wr_addr : oam_addr;
    assign OAM_WDATA    = oam_wdata;
    assign OAM_WE       = oam_we;
    assign CTRL_O       = ctrl;
    assign MASK_O       = mask;
    assign V_O          = v;
    assign T_O          = t;
    assign FINE_X_O     = fine_x;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// Directed bench for ppu_cpu_regs with a small VRAM responder (ack 3 cycles after REQ).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_ppu_cpu_regs;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [2:0]  CPU_ADDR = '0;
    logic [7:0]  CPU_DATA_IN = '0;
    logic        CPU_wren = 1'b0;
    logic        CPU_rden = 1'b0;
    logic [7:0]  CPU_DATA_OUT;
    logic        VBLANK_SET = 1'b0;
    logic        VBLANK_CLR = 1'b0;
    logic        SPR0_HIT = 1'b0;
    logic        SPR_OVF = 1'b0;
    logic        NMI_N;
    logic        VRAM_REQ;
    logic        VRAM_WE;
    logic [13:0] VRAM_ADDR;
    logic [7:0]  VRAM_WDATA;
    logic [7:0]  VRAM_RDATA;
    logic        VRAM_ACK;
    logic        BUSY;
    logic [7:0]  OAM_ADDR;
    logic [7:0]  OAM_WDATA;
    logic        OAM_WE;
    logic [7:0]  OAM_RDATA = '0;
    logic [4:0]  PAL_IDX = '0;
    logic [5:0]  PAL_COLOR;
    logic [7:0]  CTRL_O;
    logic [7:0]  MASK_O;
    logic [14:0] V_O;
    logic [14:0] T_O;
    logic [2:0]  FINE_X_O;

    int          checks = 0;
    int          errors = 0;
    int          req_starts = 0;
    int          wait_cnt = 0;
    logic        auto_ack = 1'b1;
    logic        force_ack = 1'b0;
    logic        model_ack = 1'b0;
    logic        prev_req = 1'b0;
    logic [7:0]  model_rdata = '0;
    logic [7:0]  vram [16384];
    logic [13:0] log_addr [$];
    logic [7:0]  log_data [$];

    assign VRAM_ACK   = model_ack | force_ack;
    assign VRAM_RDATA = force_ack ? 8'h99 : model_rdata;

    always #5 CLK = ~CLK;

    ppu_cpu_regs dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .CPU_ADDR     (CPU_ADDR),
        .CPU_DATA_IN  (CPU_DATA_IN),
        .CPU_wren     (CPU_wren),
        .CPU_rden     (CPU_rden),
        .CPU_DATA_OUT (CPU_DATA_OUT),
        .VBLANK_SET   (VBLANK_SET),
        .VBLANK_CLR   (VBLANK_CLR),
        .SPR0_HIT     (SPR0_HIT),
        .SPR_OVF      (SPR_OVF),
        .NMI_N        (NMI_N),
        .VRAM_REQ     (VRAM_REQ),
        .VRAM_WE      (VRAM_WE),
        .VRAM_ADDR    (VRAM_ADDR),
        .VRAM_WDATA   (VRAM_WDATA),
        .VRAM_RDATA   (VRAM_RDATA),
        .VRAM_ACK     (VRAM_ACK),
        .BUSY         (BUSY),
        .OAM_ADDR     (OAM_ADDR),
        .OAM_WDATA    (OAM_WDATA),
        .OAM_WE       (OAM_WE),
        .OAM_RDATA    (OAM_RDATA),
        .PAL_IDX      (PAL_IDX),
        .PAL_COLOR    (PAL_COLOR),
        .CTRL_O       (CTRL_O),
        .MASK_O       (MASK_O),
        .V_O          (V_O),
        .T_O          (T_O),
        .FINE_X_O     (FINE_X_O)
    );

    // VRAM responder: acknowledges each request on its third sampled cycle.
    always @(negedge CLK) begin
        if (!RESET_N) begin
            model_ack = 1'b0;
            wait_cnt  = 0;
            prev_req  = 1'b0;
        end else begin
            if (VRAM_REQ && !prev_req) req_starts++;
            prev_req = VRAM_REQ;
            if (model_ack) begin
                model_ack = 1'b0;
            end else if (VRAM_REQ && auto_ack) begin
                wait_cnt++;
                if (wait_cnt == 3) begin
                    wait_cnt    = 0;
                    model_ack   = 1'b1;
                    model_rdata = vram[VRAM_ADDR];
                    if (VRAM_WE) begin
                        vram[VRAM_ADDR] = VRAM_WDATA;
                        log_addr.push_back(VRAM_ADDR);
                        log_data.push_back(VRAM_WDATA);
                    end
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic cpu_write(input logic [2:0] a, input logic [7:0] d);
        CPU_ADDR    = a;
        CPU_DATA_IN = d;
        CPU_wren    = 1'b1;
        @(negedge CLK);
        CPU_wren    = 1'b0;
    endtask

    task automatic cpu_read(input logic [2:0] a, output logic [7:0] d);
        CPU_ADDR = a;
        CPU_rden = 1'b1;
        @(negedge CLK);
        CPU_rden = 1'b0;
        d        = CPU_DATA_OUT;
    endtask

    task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
        cpu_write(3'd6, hi);
        cpu_write(3'd6, lo);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (!BUSY) break;
            @(negedge CLK);
        end
        check_output(tag, BUSY, 0);
    endtask

    initial begin
        logic [7:0] rd;
        int         cnt0;

        for (int i = 0; i < 16384; i++) vram[i] = 8'h00;
        vram[14'h2000] = 8'h55;

        $display("[TB] reset");
        repeat (3) @(negedge CLK);
        check_output("rst_data_out", CPU_DATA_OUT, 8'h00);
        check_output("rst_nmi_n", NMI_N, 1);
        check_output("rst_req", VRAM_REQ, 0);
        check_output("rst_v", V_O, 15'h0000);
        check_output("rst_t", T_O, 15'h0000);
        RESET_N = 1'b1;
        @(negedge CLK);

        $display("[TB] scroll writes");
        cpu_write(3'd5, 8'h7D);
        check_output("scroll1_finex", FINE_X_O, 3'd5);
        cpu_write(3'd5, 8'h5E);
        check_output("scroll2_t", T_O, 15'h616F);

        $display("[TB] PPUDATA writes, +1");
        set_v(8'h21, 8'h08);
        check_output("addr_v", V_O, 15'h2108);
        check_output("addr_t", T_O, 15'h2108);
        cpu_write(3'd7, 8'hAA);
        check_output("wr_req", VRAM_REQ, 1);
        check_output("wr_we", VRAM_WE, 1);
        check_output("wr_addr", VRAM_ADDR, 14'h2108);
        check_output("wr_wdata", VRAM_WDATA, 8'hAA);
        wait_idle("wr1_idle");
        cpu_write(3'd7, 8'hBB);
        wait_idle("wr2_idle");
        check_output("inc1_v", V_O, 15'h210A);
        check_output("inc1_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check_output("inc1_a0", log_addr[0], 14'h2108);
            check_output("inc1_d0", log_data[0], 8'hAA);
            check_output("inc1_a1", log_addr[1], 14'h2109);
            check_output("inc1_d1", log_data[1], 8'hBB);
        end

        $display("[TB] PPUDATA writes, +32");
        log_addr.delete();
        log_data.delete();
        cpu_write(3'd0, 8'h04);
        check_output("ctrl_inc", CTRL_O, 8'h04);
        set_v(8'h21, 8'h08);
        cpu_write(3'd7, 8'hCC);
        wait_idle("wr3_idle");
        cpu_write(3'd7, 8'hDD);
        wait_idle("wr4_idle");
        check_output("inc32_v", V_O, 15'h2148);
        check_output("inc32_count", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check_output("inc32_a0", log_addr[0], 14'h2108);
            check_output("inc32_a1", log_addr[1], 14'h2128);
        end

        $display("[TB] buffered reads");
        cpu_write(3'd0, 8'h00);
        set_v(8'h20, 8'h00);
        cpu_read(3'd7, rd);
        check_output("rd1_buffer", rd, 8'h00);
        check_output("rd1_req", VRAM_REQ, 1);
        check_output("rd1_we", VRAM_WE, 0);
        check_output("rd1_addr", VRAM_ADDR, 14'h2000);
        wait_idle("rd1_idle");
        cnt0 = req_starts;
        cpu_read(3'd7, rd);
        check_output("rd2_buffer", rd, 8'h55);
        cpu_read(3'd7, rd);
        check_output("rd3_busy_buffer", rd, 8'h55);
        wait_idle("rd3_idle");
        check_output("rd3_no_new_req", req_starts - cnt0, 1);
        check_output("rd3_v", V_O, 15'h2003);

        $display("[TB] palette");
        PAL_IDX = 5'h10;
        set_v(8'h3F, 8'h10);
        cpu_write(3'd7, 8'h2A);
        check_output("pal_wr_no_req", VRAM_REQ, 0);
        check_output("pal_idx10", PAL_COLOR, 6'h2A);
        PAL_IDX = 5'h00;
        @(negedge CLK);
        check_output("pal_idx00", PAL_COLOR, 6'h2A);
        set_v(8'h3F, 8'h00);
        cpu_read(3'd7, rd);
        check_output("pal_rd", rd, 8'h2A);
        check_output("pal_refill_req", VRAM_REQ, 1);
        check_output("pal_refill_addr", VRAM_ADDR, 14'h2F00);
        wait_idle("pal_idle");
        cpu_write(3'd1, 8'hC0);
        check_output("mask", MASK_O, 8'hC0);
        cpu_read(3'd7, rd);
        check_output("pal_rd_latch_bits", rd, 8'hC0);
        wait_idle("pal2_idle");

        $display("[TB] OAM");
        cpu_write(3'd3, 8'h10);
        cpu_write(3'd4, 8'h77);
        check_output("oam_we", OAM_WE, 1);
        check_output("oam_waddr", OAM_ADDR, 8'h10);
        check_output("oam_wdata", OAM_WDATA, 8'h77);
        @(negedge CLK);
        check_output("oam_we_drop", OAM_WE, 0);
        check_output("oam_addr_inc", OAM_ADDR, 8'h11);
        cpu_write(3'd3, 8'hFF);
        cpu_write(3'd4, 8'h01);
        @(negedge CLK);
        check_output("oam_addr_wrap", OAM_ADDR, 8'h00);
        OAM_RDATA = 8'h5A;
        cpu_read(3'd4, rd);
        check_output("oam_rd", rd, 8'h5A);

        $display("[TB] vblank and NMI");
        cpu_write(3'd0, 8'h80);
        check_output("nmi_idle", NMI_N, 1);
        VBLANK_SET = 1'b1;
        @(negedge CLK);
        VBLANK_SET = 1'b0;
        check_output("nmi_assert", NMI_N, 0);
        cpu_read(3'd2, rd);
        check_output("status_vblank", rd, 8'h80);
        check_output("nmi_release", NMI_N, 1);
        VBLANK_SET = 1'b1;
        cpu_read(3'd2, rd);
        VBLANK_SET = 1'b0;
        check_output("status_race_rd", rd, 8'h00);
        check_output("status_race_nmi", NMI_N, 0);
        VBLANK_CLR = 1'b1;
        @(negedge CLK);
        VBLANK_CLR = 1'b0;
        check_output("vblank_clr_nmi", NMI_N, 1);
        VBLANK_SET = 1'b1;
        VBLANK_CLR = 1'b1;
        @(negedge CLK);
        VBLANK_SET = 1'b0;
        VBLANK_CLR = 1'b0;
        check_output("set_clr_nmi", NMI_N, 1);
        SPR0_HIT = 1'b1;
        @(negedge CLK);
        SPR0_HIT = 1'b0;
        cpu_read(3'd2, rd);
        check_output("status_spr0", rd, 8'h40);

        $display("[TB] reset mid-transaction");
        auto_ack = 1'b0;
        set_v(8'h21, 8'h00);
        cpu_read(3'd7, rd);
        cpu_read(3'd2, rd);
        cpu_write(3'd6, 8'h21);
        VBLANK_SET = 1'b1;
        @(negedge CLK);
        VBLANK_SET = 1'b0;
        check_output("pre_rst_busy", BUSY, 1);
        check_output("pre_rst_nmi", NMI_N, 0);
        RESET_N = 1'b0;
        @(negedge CLK);
        check_output("mid_rst_req", VRAM_REQ, 0);
        check_output("mid_rst_we", VRAM_WE, 0);
        check_output("mid_rst_nmi", NMI_N, 1);
        check_output("mid_rst_data_out", CPU_DATA_OUT, 8'h00);
        check_output("mid_rst_ctrl", CTRL_O, 8'h00);
        check_output("mid_rst_mask", MASK_O, 8'h00);
        check_output("mid_rst_v", V_O, 15'h0000);
        check_output("mid_rst_t", T_O, 15'h0000);
        check_output("mid_rst_oam_addr", OAM_ADDR, 8'h00);
        check_output("mid_rst_pal", PAL_COLOR, 6'h00);
        RESET_N = 1'b1;
        @(negedge CLK);
        force_ack = 1'b1;
        @(negedge CLK);
        force_ack = 1'b0;
        check_output("late_ack_req", VRAM_REQ, 0);
        cpu_read(3'd7, rd);
        check_output("late_ack_buffer", rd, 8'h00);
        cpu_write(3'd6, 8'h3F);
        check_output("rst_w_cleared", T_O, 15'h3F00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule

// File: doc/ppu_cpu_regs.md
# ppu_cpu_regs

Parametrised CPU-facing register file for the PPU: decodes the eight mirrored registers ($2000–$2007), owns the scroll/address registers (v, t, fine-x, write toggle), the PPUDATA read buffer, the open-bus latch, VBLANK/NMI status and an internal 32-entry palette RAM. It sits between the CPU bus decoder and the PPU renderer. VRAM traffic goes out on a request/acknowledge port, so the block works with any VRAM latency. Renderer-visible state (CTRL, MASK, v, t, fine-x) is exported for the background/sprite pipelines.

## Interface
Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- VADDR_W, 14: VRAM address width; v and t are VADDR_W+1 bits (bit VADDR_W is the loopy fine-Y MSB).
- PAL_BASE, 14'h3F00: start of the palette window; the window is a 256-byte region, mirrored every 32 bytes.
- INC_DOWN, 32: PPUDATA increment when CTRL[2]=1.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  async active-low reset
- CPU_ADDR  in  3  register index
- CPU_DATA_IN  in  8  CPU write data
- CPU_wren / CPU_rden  in  1 each  single-cycle strobes, never both high
- CPU_DATA_OUT  out  8  read data, registered
- VBLANK_SET / VBLANK_CLR  in  1 each  pulses from the timing generator (scanline 241 dot 1 / pre-render dot 1)
- SPR0_HIT / SPR_OVF  in  1 each  set pulses from the sprite unit
- NMI_N  out  1  active-low NMI, registered
- VRAM_REQ  out  1  held high until ack
- VRAM_WE  out  1  1 = write
- VRAM_ADDR  out  VADDR_W  address
- VRAM_WDATA  out  8  write data
- VRAM_RDATA  in  8  read data, valid with ack
- VRAM_ACK  in  1  one-cycle completion
- BUSY  out  1  VRAM transaction outstanding
- OAM_ADDR  out  8  OAM address
- OAM_WDATA  out  8  OAM write data
- OAM_WE  out  1  OAM write strobe
- OAM_RDATA  in  8  OAM read data
- PAL_IDX  in  5  renderer palette lookup index
- PAL_COLOR  out  6  renderer palette lookup result, combinational
- CTRL_O / MASK_O  out  8 each  register copies for the renderer
- V_O / T_O  out  VADDR_W+1 each  loopy v and t
- FINE_X_O  out  3  fine-x scroll

## Operation
Writes (every CPU write loads the open-bus latch with the data):
- $2000: CTRL <= d; t[11:10] <= d[1:0].
- $2001: MASK <= d.
- $2003: OAMADDR <= d.
- $2004: pulse OAM_WE with OAM_WDATA=d; OAMADDR += 1, wrapping 8-bit.
- $2005, w=0: t[4:0] <= d[7:3]; fine_x <= d[2:0]; w <= 1.
- $2005, w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
- $2006, w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
- $2006, w=1: t[7:0] <= d; v <= {t[14:8], d}; w <= 0.
- $2007 write, palette window (v[13:0] in PAL_BASE..PAL_BASE+255): write palette RAM[v[4:0]], no bus cycle.
- $2007 write, otherwise: start a VRAM write at v.
- Every $2007 write increments v by 1 (CTRL[2]=0) or INC_DOWN (CTRL[2]=1), modulo 2^(VADDR_W+1).

Reads:
- $2002: returns {vblank, spr0, ovf, latch[4:0]}; clears vblank and w.
- $2004: returns OAM_RDATA.
- $2007, non-palette: returns the read buffer; starts a VRAM read at v; the buffer loads VRAM_RDATA on ack.
- $2007, palette: returns {latch[7:6], pal[v[4:0]]}; starts a buffer refill read at v − $1000.
- $2007 reads increment v exactly like writes.
- $2000, $2001, $2003, $2005, $2006: return the latch.
- Every read loads the latch with the returned value.

Palette RAM:
- Entries $10/$14/$18/$1C alias $00/$04/$08/$0C on both write and read.
- PAL_IDX uses the same aliasing.

Status:
- vblank is set by VBLANK_SET and cleared by VBLANK_CLR or a $2002 read.
- spr0 and ovf are set by their pulses and cleared by VBLANK_CLR.
- NMI_N <= ~(vblank & CTRL[7]).

## Timing
- CPU_DATA_OUT and the side effects of a read are valid the cycle after CPU_rden. Write effects are visible the cycle after CPU_wren.
- VRAM port: REQ, WE, ADDR and WDATA rise the cycle after the $2007 access and stay stable until the cycle VRAM_ACK=1. REQ drops the cycle after ack. BUSY = REQ.
- A $2007 access while BUSY: no new bus cycle starts and the access is not queued. v still increments and a read returns the current buffer.
- VBLANK_SET in the same cycle as a $2002 read: the read returns vblank=0 and the flag ends set (set wins).
- VBLANK_SET and VBLANK_CLR in the same cycle: clear wins.
- Reset values:
  - CTRL, MASK, OAMADDR, v, t, fine_x, w, buffer, latch, status flags, palette RAM, CPU_DATA_OUT: 0.
  - NMI_N: 1.
  - VRAM_REQ, VRAM_WE, OAM_WE: 0.
- Reset during an outstanding VRAM transaction abandons it; a late ack is ignored.

## Structure
- Package ppu_pkg holds:
  - register index enum (REG_CTRL..REG_DATA);
  - loopy address struct (coarse_x 5, coarse_y 5, nt 2, fine_y 3);
  - status bit positions;
  - palette alias function.
- Sub-module ppu_palette_ram: 32×6 storage with aliasing, one write port plus two async read ports (CPU and renderer).

## Test plan
- $2005←$7D then $2005←$5E: t=$616F, fine_x=5, w=0.
- $2006←$21, $2006←$08, then $2007 writes $AA, $BB with CTRL[2]=0: VRAM writes at $2108 and $2109; v ends at $210A. Repeat with CTRL[2]=1: writes at $2108 and $2128.
- VRAM holds $2000=$55 and ack arrives 3 cycles after REQ: first $2007 read returns 0, second returns $55. A third read issued while BUSY causes no new REQ.
- Write $3F10←$2A, read $3F00: immediate $2A (bits 7:6 from the latch). PAL_IDX=$10 also yields $2A.
- With CTRL[7]=1, VBLANK_SET: NMI_N=0 next cycle. A $2002 read then returns bit7=1 and NMI_N returns to 1. A $2002 read coincident with VBLANK_SET returns bit7=0 and NMI_N goes 0.
- Assert RESET_N low mid-transaction with w=1: all outputs are at their reset values; a subsequent VRAM_ACK changes no state.
